// File: rtl/jsq1_pkg.sv
// Shared constants and helpers for the jsq1 pulse counter.
package jsq1_pkg;

  localparam int DEF_PULSE_LEN = 10;

  // Counter width for a count of n states, never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = (n > 1) ? $clog2(n) : 1;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/jsq1_pulse_counter_cnt_gen.sv
// Generic up-counter: advances while add_cnt is high and wraps to zero after END_VAL counts.
module cnt_gen
  import jsq1_pkg::*;
#(
  parameter int END_VAL = DEF_PULSE_LEN,
  parameter int CNT_W   = cnt_width(DEF_PULSE_LEN)
) (
  input  logic clk,
  input  logic rst,
  input  logic add_cnt,
  input  logic clear,
  output logic end_cnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(END_VAL - 1);

  logic [CNT_W-1:0] cnt;

  assign end_cnt = add_cnt && (cnt == LAST);

  // Clearing at LAST keeps the count inside 0..END_VAL-1, so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || end_cnt) begin
      cnt <= '0;
    end else if (add_cnt) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/jsq1_pulse_counter.sv
// Single-shot pulse generator: a strobe on en raises dout for exactly PULSE_LEN cycles.
module jsq1_pulse_counter
  import jsq1_pkg::*;
#(
  parameter int PULSE_LEN = DEF_PULSE_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic dout
);

  localparam int CNT_W = cnt_width(PULSE_LEN);

  logic busy;
  logic start;
  logic end_cnt;

  // en is only honoured while idle; strobes during a pulse, including its last cycle, are dropped.
  assign start = en && !busy;

  cnt_gen #(
    .END_VAL (PULSE_LEN),
    .CNT_W   (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst_n),
    .add_cnt (busy),
    .clear   (start),
    .end_cnt (end_cnt)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      busy <= 1'b0;
    end else if (start) begin
      busy <= 1'b1;
    end else if (end_cnt) begin
      busy <= 1'b0;
    end
  end

  assign dout = busy;

endmodule

// File: tb/tb_jsq1_pulse_counter.sv
// Directed bench for jsq1_pulse_counter: per-cycle vector table plus an async-reset sequence.
module tb_jsq1_pulse_counter;

  logic clk;
  logic rst_n;
  logic en;
  logic dout;

  int n_tests;
  int n_fail;

  typedef struct {
    logic rst;
    logic en;
    logic exp_dout;
  } vec_t;

  vec_t vecs[$];

  jsq1_pulse_counter #(.PULSE_LEN(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .dout  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic e, input logic d, input int n);
    vec_t v;
    v.rst = r;
    v.en = e;
    v.exp_dout = d;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  initial begin
    int highs;
    n_tests = 0;
    n_fail = 0;
    en = 1'b0;
    rst_n = 1'b0;
    #1 rst_n = 1'b1;

    // Reset held 10 cycles (en asserted in the later ones must have no effect), then idle.
    add(1, 0, 0, 6);
    add(1, 1, 0, 4);
    add(0, 0, 0, 10);
    // Single strobe: 10 high cycles then low.
    add(0, 1, 1, 1);
    add(0, 0, 1, 9);
    add(0, 0, 0, 5);
    // Two strobes 16 cycles apart: 6 low cycles between pulses.
    add(0, 1, 1, 1);
    add(0, 0, 1, 9);
    add(0, 0, 0, 6);
    add(0, 1, 1, 1);
    add(0, 0, 1, 9);
    add(0, 0, 0, 3);
    // Retrigger 4 cycles into a pulse is ignored.
    add(0, 1, 1, 1);
    add(0, 0, 1, 3);
    add(0, 1, 1, 1);
    add(0, 0, 1, 5);
    add(0, 0, 0, 12);
    // en held for 25 cycles: 10 high, 1 low, 10 high, 1 low, third pulse runs out.
    add(0, 1, 1, 10);
    add(0, 1, 0, 1);
    add(0, 1, 1, 10);
    add(0, 1, 0, 1);
    add(0, 1, 1, 3);
    add(0, 0, 1, 7);
    add(0, 0, 0, 3);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rst;
      en = vecs[i].en;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_dout", i), {31'd0, dout}, {31'd0, vecs[i].exp_dout});
      if (!vecs[i].exp_dout)
        check($sformatf("vec%0d_cnt", i), 32'(dut.u_cnt.cnt), 32'd0);
    end

    // Async reset 5 cycles into a pulse.
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1 check("arst_start", {31'd0, dout}, 32'd1);
    @(negedge clk);
    en = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("arst_dout", {31'd0, dout}, 32'd0);
    check("arst_cnt", 32'(dut.u_cnt.cnt), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 check($sformatf("post_arst%0d", i), {31'd0, dout}, 32'd0);
    end
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1 check("rearm_start", {31'd0, dout}, 32'd1);
    highs = 1;
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1 if (dout) highs++;
    end
    check("rearm_len", 32'(highs), 32'd10);
    check("rearm_end", {31'd0, dout}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
